// File: rtl/led_fade_seq.sv
// led_fade_seq: debounced push button steps OFF/ON/BREATHE/BLINK and drives an 8-bit PWM duty offer.
// Latency: press recognised -> mode/mode_changed 1 cycle later; level change -> duty_valid 1 cycle later.
// Backpressure: duty held stable while duty_valid & !duty_ready; only the latest target is offered next.
//
// Ports:
//   clk          system clock (25 MHz nominal)
//   rst_n        asynchronous active-low reset
//   btn_n        raw active-low push button, asynchronous to clk
//   duty_ready   PWM stage accepts the offered duty this cycle
//   duty         offered duty value (0 = dark, DUTY_MAX = full)
//   duty_valid   duty holds an offer not yet accepted
//   mode         current mode: 0 OFF, 1 ON, 2 BREATHE, 3 BLINK
//   mode_changed one-cycle pulse in the cycle mode updates
//
// Build option: define GAMMA_EN to map level -> duty through (level*(level+2))>>8
// (perceptual gamma of about 2); without it duty follows level directly.
module led_fade_seq #(
  parameter int STEP_CYCLES     = 250_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int STEP_INC        = 3,
  parameter int BLINK_TICKS     = 50,
  parameter int DUTY_MAX        = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       duty_ready,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic [1:0] mode,
  output logic       mode_changed
);

  // Counter widths; guard against a 1-cycle parameter collapsing $clog2 to 0.
  localparam int PRE_W = (STEP_CYCLES     > 1) ? $clog2(STEP_CYCLES)     : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W  = (BLINK_TICKS     > 1) ? $clog2(BLINK_TICKS)     : 1;

  localparam logic [PRE_W-1:0] LP_PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [DB_W-1:0]  LP_DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0]  LP_BL_LAST  = BL_W'(BLINK_TICKS - 1);

  localparam logic [7:0] LP_MAX  = 8'(DUTY_MAX);
  localparam logic [7:0] LP_STEP = 8'(STEP_INC);
  // BREATHE limits are compared in 9 bits so the level can never wrap.
  localparam logic [8:0] LP_UP_THR = 9'(DUTY_MAX - STEP_INC);
  localparam logic [8:0] LP_DN_THR = 9'(STEP_INC);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_stable;
  logic            r_btn_prev;
  logic            w_press;

  // Synchroniser resets to "released" so reset release cannot fake a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // The synchronised level must differ from the stable state for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken; any return to the
  // stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt     <= '0;
      r_btn_stable <= 1'b1;
      r_btn_prev   <= 1'b1;
    end else begin
      r_btn_prev <= r_btn_stable;
      if (r_sync2 == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == LP_DB_LAST) begin
        r_btn_stable <= r_sync2;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Press = stable state fell 1->0 on the previous edge; release is ignored.
  assign w_press = r_btn_prev & ~r_btn_stable;

  // ---------------------------------------------------------------------------
  // Mode FSM, tick prescaler and level generator
  // ---------------------------------------------------------------------------
  mode_e            r_mode;
  mode_e            w_next_mode;
  logic             r_mode_changed;
  logic [PRE_W-1:0] r_pre;
  logic [BL_W-1:0]  r_blink_cnt;
  logic [7:0]       r_level;
  logic             r_dir_up;
  logic             w_tick;

  always_comb begin
    w_next_mode = MODE_OFF;
    case (r_mode)
      MODE_OFF:     w_next_mode = MODE_ON;
      MODE_ON:      w_next_mode = MODE_BREATHE;
      MODE_BREATHE: w_next_mode = MODE_BLINK;
      MODE_BLINK:   w_next_mode = MODE_OFF;
      default:      w_next_mode = MODE_OFF;
    endcase
  end

  assign w_tick = (r_pre == LP_PRE_LAST);

  // A press takes priority over a coincident tick: the mode change restarts
  // the prescaler and blink counter, so that tick is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode         <= MODE_OFF;
      r_mode_changed <= 1'b0;
      r_pre          <= '0;
      r_blink_cnt    <= '0;
      r_level        <= 8'd0;
      r_dir_up       <= 1'b1;
    end else begin
      r_mode_changed <= w_press;
      if (w_press) begin
        r_mode      <= w_next_mode;
        r_pre       <= '0;
        r_blink_cnt <= '0;
        case (w_next_mode)
          MODE_OFF: r_level <= 8'd0;
          MODE_ON:  r_level <= LP_MAX;
          MODE_BREATHE: begin
            r_level  <= 8'd0;
            r_dir_up <= 1'b1;
          end
          MODE_BLINK: r_level <= LP_MAX;
          default:    r_level <= 8'd0;
        endcase
      end else begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
        case (r_mode)
          MODE_OFF: r_level <= 8'd0;
          MODE_ON:  r_level <= LP_MAX;
          MODE_BREATHE: begin
            if (w_tick) begin
              if (r_dir_up) begin
                // Clamp at the top and turn around rather than overshoot.
                if ({1'b0, r_level} >= LP_UP_THR) begin
                  r_level  <= LP_MAX;
                  r_dir_up <= 1'b0;
                end else begin
                  r_level <= r_level + LP_STEP;
                end
              end else begin
                if ({1'b0, r_level} <= LP_DN_THR) begin
                  r_level  <= 8'd0;
                  r_dir_up <= 1'b1;
                end else begin
                  r_level <= r_level - LP_STEP;
                end
              end
            end
          end
          MODE_BLINK: begin
            if (w_tick) begin
              if (r_blink_cnt == LP_BL_LAST) begin
                r_blink_cnt <= '0;
                r_level     <= (r_level == LP_MAX) ? 8'd0 : LP_MAX;
              end else begin
                r_blink_cnt <= r_blink_cnt + BL_W'(1);
              end
            end
          end
          default: r_level <= 8'd0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Duty mapping and valid/ready offer
  // ---------------------------------------------------------------------------
  logic [7:0] w_target;
  logic [7:0] r_duty;
  logic       r_duty_valid;
  logic       w_accept;

`ifdef GAMMA_EN
  // level*(level+2) peaks at 255*257 = 65535, so a 16-bit product is exact.
  assign w_target = 8'((16'(r_level) * (16'(r_level) + 16'd2)) >> 8);
`else
  assign w_target = r_level;
`endif

  assign w_accept = r_duty_valid & duty_ready;

  // A new offer is loaded only when the slot is empty or being emptied this
  // cycle, so an un-accepted offer never changes and intermediate levels
  // collapse into whatever the target is once the slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty       <= 8'd0;
      r_duty_valid <= 1'b0;
    end else if ((!r_duty_valid || w_accept) && (w_target != r_duty)) begin
      r_duty       <= w_target;
      r_duty_valid <= 1'b1;
    end else if (w_accept) begin
      r_duty_valid <= 1'b0;
    end
  end

  assign duty         = r_duty;
  assign duty_valid   = r_duty_valid;
  assign mode         = r_mode;
  assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_led_fade_seq.sv
// tb_led_fade_seq: scoreboard bench for led_fade_seq with a behavioural reference model.
// Latency: model predicts each accepted duty and each mode change with its clock-edge index.
// Backpressure: duty_ready is driven both directed and randomly; held offers are checked for stability.
module tb_led_fade_seq;

  localparam int STEP = 4;
  localparam int DEB  = 8;
  localparam int SINC = 51;
  localparam int BT   = 2;
  localparam int DMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       duty_ready;
  logic [7:0] duty;
  logic       duty_valid;
  logic [1:0] mode;
  logic       mode_changed;

  led_fade_seq #(
    .STEP_CYCLES    (STEP),
    .DEBOUNCE_CYCLES(DEB),
    .STEP_INC       (SINC),
    .BLINK_TICKS    (BT),
    .DUTY_MAX       (DMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_n),
    .duty_ready  (duty_ready),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;   // number of rising edges so far

  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t acc_q[$];    // predicted accepted duty values, tagged with accept edge
  exp_t mode_q[$];   // predicted mode changes, tagged with update edge

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Evaluated at the falling edge, it predicts what the next
  // rising edge does from the inputs that edge will sample.
  // ---------------------------------------------------------------------------
  int m_s1, m_s2;        // two-stage synchroniser contents
  int m_stable;          // debounced button level
  int m_run;             // consecutive edges the synchronised level differed
  int m_pend;            // a press was recognised on the previous edge
  int m_mode;
  int m_k;               // edges since the last mode entry (or reset)
  int m_ticks;           // ticks since the last mode entry
  int m_level;
  int m_up;
  int m_duty;
  int m_valid;

  function automatic int map_duty(input int lv);
`ifdef GAMMA_EN
    return (lv * (lv + 2)) / 256;
`else
    return lv;
`endif
  endfunction

  function automatic int entry_level(input int md);
    return (md == 1 || md == 3) ? DMAX : 0;
  endfunction

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0; m_pend = 0;
    m_mode = 0; m_k = 0; m_ticks = 0; m_level = 0; m_up = 1;
    m_duty = 0; m_valid = 0;
    acc_q.delete();
    mode_q.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin : model
    int  e;
    int  tgt;
    bit  acc;
    bit  new_press;
    if (!rst_n) begin
      model_reset();
    end else begin
      e = cyc + 1;
      // Offer slot: an offer changes only when empty or being taken.
      tgt = map_duty(m_level);
      acc = (m_valid != 0) && duty_ready;
      if (acc) acc_q.push_back('{cyc: e, val: m_duty});
      if ((m_valid == 0 || acc) && tgt != m_duty) begin
        m_duty  = tgt;
        m_valid = 1;
      end else if (acc) begin
        m_valid = 0;
      end
      // Mode and level.
      if (m_pend != 0) begin
        m_mode  = (m_mode + 1) % 4;
        mode_q.push_back('{cyc: e, val: m_mode});
        m_k     = 0;
        m_ticks = 0;
        m_level = entry_level(m_mode);
        m_up    = 1;
      end else begin
        m_k++;
        if (m_k % STEP == 0) begin
          m_ticks++;
          if (m_mode == 2) begin
            if (m_up != 0) begin
              if (m_level >= DMAX - SINC) begin m_level = DMAX; m_up = 0; end
              else m_level = m_level + SINC;
            end else begin
              if (m_level <= SINC) begin m_level = 0; m_up = 1; end
              else m_level = m_level - SINC;
            end
          end else if (m_mode == 3 && m_ticks % BT == 0) begin
            m_level = ((m_ticks / BT) % 2 == 1) ? 0 : DMAX;
          end
        end
      end
      // Debounce: accept a level that has differed for DEB edges in a row.
      new_press = 0;
      if (m_s2 != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = m_s2;
          m_run    = 0;
          if (m_stable == 0) new_press = 1;
        end
      end else begin
        m_run = 0;
      end
      m_pend = new_press;
      m_s2   = m_s1;
      m_s1   = btn_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops a prediction whenever the DUT shows a transfer or a mode pulse.
  // ---------------------------------------------------------------------------
  bit         prev_hold = 0;
  logic [7:0] prev_duty = 8'd0;

  always @(negedge clk) begin : monitor
    exp_t x;
    #1;
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", int'(duty_valid), 1);
        check("hold_duty", int'(duty), int'(prev_duty));
      end
      if (duty_valid && duty_ready) begin
        if (acc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_unexpected: got accept of duty %0d at edge %0d, required none", duty, cyc + 1);
        end else begin
          x = acc_q.pop_front();
          check("accept_duty", int'(duty), x.val);
          check("accept_edge", cyc + 1, x.cyc);
        end
      end
      if (mode_changed) begin
        if (mode_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mode_pulse_unexpected: got pulse with mode %0d at edge %0d, required none", mode, cyc);
        end else begin
          x = mode_q.pop_front();
          check("mode_value", int'(mode), x.val);
          check("mode_edge", cyc, x.cyc);
        end
      end
      prev_hold = duty_valid && !duty_ready;
      prev_duty = duty;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after each rising edge.
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rand_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      duty_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic press(input int lo, input int hi);
    btn_n = 1'b0;
    wait_cyc(lo);
    btn_n = 1'b1;
    wait_cyc(hi);
  endtask

  initial begin : stim
    bit found;
    rst_n      = 1'b0;
    btn_n      = 1'b1;
    duty_ready = 1'b1;
    wait_cyc(3);
    check("reset_duty", int'(duty), 0);
    check("reset_valid", int'(duty_valid), 0);
    check("reset_mode", int'(mode), 0);
    check("reset_mode_changed", int'(mode_changed), 0);
    rst_n = 1'b1;

    // Idle in OFF: nothing should be offered.
    wait_cyc(100);
    check("idle_valid", int'(duty_valid), 0);

    // Press into ON, then a short glitch that must be ignored.
    press(20, 20);
    check("mode_on", int'(mode), 1);
    press(5, 20);
    check("mode_after_glitch", int'(mode), 1);

    // BREATHE ramp with the sink always ready.
    press(20, 20);
    check("mode_breathe", int'(mode), 2);
    wait_cyc(80);

    // Backpressure: offer must be raised and held, then coalesce on release.
    duty_ready = 1'b0;
    wait_cyc(20);
    check("backpressure_valid", int'(duty_valid), 1);
    duty_ready = 1'b1;
    wait_cyc(20);

    // BLINK.
    press(20, 20);
    check("mode_blink", int'(mode), 3);
    wait_cyc(40);

    // Reset while an offer is pending.
    duty_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (duty_valid) found = 1;
    end
    check("offer_before_reset", int'(found), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(duty_valid), 0);
    check("async_reset_mode", int'(mode), 0);
    check("async_reset_duty", int'(duty), 0);
    wait_cyc(3);
    rst_n      = 1'b1;
    duty_ready = 1'b1;

    // Randomised presses, glitches and backpressure.
    for (int it = 0; it < 150; it++) begin
      int lo;
      int hi;
      lo = $urandom_range(1, 20);
      hi = $urandom_range(1, 20);
      btn_n = 1'b0;
      rand_cyc(lo);
      btn_n = 1'b1;
      rand_cyc(hi);
    end

    // Drain and confirm every prediction was matched.
    btn_n      = 1'b1;
    duty_ready = 1'b1;
    wait_cyc(60);
    check("accept_queue_drained", acc_q.size(), 0);
    check("mode_queue_drained", mode_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
